present_sbox_layer_dr: RTL and testbench

- Sequential, parametrised PRESENT S-box layer with dual-rail precharge/evaluate outputs. Generalises the single-output dual-rail S-box bit-slice.
- Takes a full NIBBLES-wide state and evaluates LANES nibbles per evaluate phase, each evaluate phase preceded by a precharge phase.
- Drives complementary rails (out_u = S(x), out_c = ~S(x)) and checks rail complementarity.
- Sits between the round-key XOR and the permutation layer of the cipher datapath.

---
 rtl/present_sbox_pkg.sv | 23 ++
 rtl/present_sbox_lane_dr.sv | 23 ++
 rtl/present_sbox_layer_dr.sv | 152 +++++++++++++++
 tb/tb_present_sbox_layer_dr.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/present_sbox_pkg.sv
// Shared definitions for the dual-rail PRESENT S-box layer:
// S-box table and lookup function, FSM state type, nibble width.
package present_sbox_pkg;

  localparam int NIB_W = 4;

  localparam logic [NIB_W-1:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  function automatic logic [NIB_W-1:0] sbox4(input logic [NIB_W-1:0] x);
    return SBOX[x];
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_EVAL = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/present_sbox_lane_dr.sv
// One dual-rail S-box lane. Both rails sit at 0 unless the lane is being
// evaluated (and not precharging); then u = S(x) and c = ~S(x).
module present_sbox_lane_dr
  import present_sbox_pkg::*;
(
  input  logic             i_pre,
  input  logic             i_eval,
  input  logic [NIB_W-1:0] i_x,
  output logic [NIB_W-1:0] o_u,
  output logic [NIB_W-1:0] o_c
);

  // Rails are precharged low by default and only driven during evaluation.
  always_comb begin
    o_u = '0;
    o_c = '0;
    if (i_eval && !i_pre) begin
      o_u = sbox4(i_x);
      o_c = ~sbox4(i_x);
    end
  end

endmodule

// File: rtl/present_sbox_layer_dr.sv
// Sequential PRESENT S-box layer with dual-rail outputs.
// The state is processed LANES nibbles at a time in ascending group order;
// each group gets PRE_CYCLES precharge cycles followed by one evaluate cycle.
// Rails of groups not yet evaluated read 0/0. Any written bit pair with
// equal rails raises the sticky fault flag.
// Optional macro PRESENT_SBOX_FAULT_INJECT_EN adds i_inj_mask, XORed onto
// the uncomplemented rail of the group being evaluated.
//
//   state | meaning
//   IDLE  | ready for a new state, rails hold the last result
//   PRE   | precharging the current group (PRE_CYCLES cycles)
//   EVAL  | write S(x)/~S(x) of the current group, check complementarity
//   DONE  | result valid and stable until accepted
module present_sbox_layer_dr
  import present_sbox_pkg::*;
#(
  parameter int NIBBLES    = 16,
  parameter int LANES      = 4,
  parameter int PRE_CYCLES = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic [NIB_W*NIBBLES-1:0] i_in_data,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [NIB_W*NIBBLES-1:0] o_out_u,
  output logic [NIB_W*NIBBLES-1:0] o_out_c,
  output logic                     o_pre_phase,
  output logic                     o_busy,
`ifdef PRESENT_SBOX_FAULT_INJECT_EN
  input  logic [NIB_W*LANES-1:0]   i_inj_mask,
`endif
  output logic                     o_fault
);

  localparam int G    = NIBBLES / LANES;
  localparam int W    = NIB_W * NIBBLES;
  localparam int GW   = NIB_W * LANES;
  localparam int G_W  = (G > 1) ? $clog2(G) : 1;
  localparam int PC_W = (PRE_CYCLES > 1) ? $clog2(PRE_CYCLES) : 1;

  localparam logic [G_W-1:0]  GRP_LAST = G_W'(G - 1);
  localparam logic [PC_W-1:0] PRE_LOAD = PC_W'(PRE_CYCLES - 1);

  state_t          r_state;
  state_t          w_next;
  logic [W-1:0]    r_data;
  logic [G_W-1:0]  r_grp;
  logic [PC_W-1:0] r_pre_cnt;
  logic [W-1:0]    r_out_u;
  logic [W-1:0]    r_out_c;
  logic            r_fault;

  logic [GW-1:0]   w_grp_x;
  logic [GW-1:0]   w_lane_u;
  logic [GW-1:0]   w_lane_c;
  logic [GW-1:0]   w_inj;
  logic [GW-1:0]   w_u_wr;
  logic            w_pre;
  logic            w_eval;
  logic            w_last_grp;

  assign w_pre      = (r_state == ST_PRE);
  assign w_eval     = (r_state == ST_EVAL);
  assign w_last_grp = (r_grp == GRP_LAST);
  assign w_grp_x    = r_data[r_grp*GW +: GW];

`ifdef PRESENT_SBOX_FAULT_INJECT_EN
  assign w_inj = i_inj_mask;
`else
  assign w_inj = '0;
`endif

  assign w_u_wr = w_lane_u ^ w_inj;

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    present_sbox_lane_dr u_lane (
      .i_pre  (w_pre),
      .i_eval (w_eval),
      .i_x    (w_grp_x[j*NIB_W +: NIB_W]),
      .o_u    (w_lane_u[j*NIB_W +: NIB_W]),
      .o_c    (w_lane_c[j*NIB_W +: NIB_W])
    );
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Next-state decode; the precharge timer is a down-counter ending at 0.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (i_in_valid)       w_next = ST_PRE;
      ST_PRE:  if (r_pre_cnt == '0)  w_next = ST_EVAL;
      ST_EVAL: w_next = w_last_grp ? ST_DONE : ST_PRE;
      ST_DONE: if (i_out_ready)      w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Datapath: latch input, run timers/group counter, write evaluated rails.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data    <= '0;
      r_grp     <= '0;
      r_pre_cnt <= '0;
      r_out_u   <= '0;
      r_out_c   <= '0;
      r_fault   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_in_valid) begin
            r_data    <= i_in_data;
            r_out_u   <= '0;
            r_out_c   <= '0;
            r_fault   <= 1'b0;
            r_grp     <= '0;
            r_pre_cnt <= PRE_LOAD;
          end
        end
        ST_PRE: begin
          if (r_pre_cnt != '0) r_pre_cnt <= r_pre_cnt - PC_W'(1);
        end
        ST_EVAL: begin
          r_out_u[r_grp*GW +: GW] <= w_u_wr;
          r_out_c[r_grp*GW +: GW] <= w_lane_c;
          if (|(~(w_u_wr ^ w_lane_c))) r_fault <= 1'b1;
          if (!w_last_grp) begin
            r_grp     <= r_grp + G_W'(1);
            r_pre_cnt <= PRE_LOAD;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_in_ready  = (r_state == ST_IDLE);
  assign o_out_valid = (r_state == ST_DONE);
  assign o_pre_phase = w_pre;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_out_u     = r_out_u;
  assign o_out_c     = r_out_c;
  assign o_fault     = r_fault;

endmodule

// File: tb/tb_present_sbox_layer_dr.sv
// Bench for present_sbox_layer_dr: default instance plus LANES=1 and
// LANES=16 instances (both PRE_CYCLES=2), checked against a nibble-wise
// S-table model with group progress computed from elapsed cycles.
module tb_present_sbox_layer_dr;

  localparam int P  = 1;
  localparam int L  = 4;
  localparam int G  = 16 / L;
  localparam int LAT = G * (P + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_ready, out_valid, pre_phase, busy, fault;
  logic [63:0] out_u, out_c;

  logic        a_in_valid = 1'b0, a_out_ready = 1'b1;
  logic [63:0] a_in_data = '0;
  logic        a_in_ready, a_out_valid, a_pre_phase, a_busy, a_fault;
  logic [63:0] a_out_u, a_out_c;

  logic        b_in_valid = 1'b0, b_out_ready = 1'b1;
  logic [63:0] b_in_data = '0;
  logic        b_in_ready, b_out_valid, b_pre_phase, b_busy, b_fault;
  logic [63:0] b_out_u, b_out_c;

`ifdef PRESENT_SBOX_FAULT_INJECT_EN
  logic [15:0] inj_mask = '0;
  logic [3:0]  a_inj = '0;
  logic [63:0] b_inj = '0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  present_sbox_layer_dr #(.NIBBLES(16), .LANES(L), .PRE_CYCLES(P)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_data(in_data), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_u(out_u), .o_out_c(out_c), .o_pre_phase(pre_phase), .o_busy(busy),
`ifdef PRESENT_SBOX_FAULT_INJECT_EN
    .i_inj_mask(inj_mask),
`endif
    .o_fault(fault));

  present_sbox_layer_dr #(.NIBBLES(16), .LANES(1), .PRE_CYCLES(2)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(a_in_valid), .o_in_ready(a_in_ready),
    .i_in_data(a_in_data), .o_out_valid(a_out_valid), .i_out_ready(a_out_ready),
    .o_out_u(a_out_u), .o_out_c(a_out_c), .o_pre_phase(a_pre_phase), .o_busy(a_busy),
`ifdef PRESENT_SBOX_FAULT_INJECT_EN
    .i_inj_mask(a_inj),
`endif
    .o_fault(a_fault));

  present_sbox_layer_dr #(.NIBBLES(16), .LANES(16), .PRE_CYCLES(2)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(b_in_valid), .o_in_ready(b_in_ready),
    .i_in_data(b_in_data), .o_out_valid(b_out_valid), .i_out_ready(b_out_ready),
    .o_out_u(b_out_u), .o_out_c(b_out_c), .o_pre_phase(b_pre_phase), .o_busy(b_busy),
`ifdef PRESENT_SBOX_FAULT_INJECT_EN
    .i_inj_mask(b_inj),
`endif
    .o_fault(b_fault));

  // ---------------- reference model ----------------
  function automatic logic [3:0] ref_s(input logic [3:0] x);
    logic [63:0] tbl;
    tbl = 64'h21748FE3DA09B65C;
    return tbl[x*4 +: 4];
  endfunction

  // Rails after ndone groups of 'lanes' nibbles have been evaluated: {u, c}.
  function automatic logic [127:0] ref_rails(input logic [63:0] x, input int ndone, input int lanes);
    logic [63:0] u, c;
    u = '0;
    c = '0;
    for (int n = 0; n < 16; n++) begin
      if (n < ndone * lanes) begin
        u[n*4 +: 4] = ref_s(x[n*4 +: 4]);
        c[n*4 +: 4] = ~ref_s(x[n*4 +: 4]);
      end
    end
    return {u, c};
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // ---------------- drive / wait helpers (no comparisons) ----------------
  task automatic accept(input logic [63:0] d);
    in_data = d; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if ({out_valid, pre_phase, busy, fault} !== 4'b0) begin n_errors++;
      $display("FAIL reset_flags got=%b want=0000", {out_valid, pre_phase, busy, fault}); end
    n_checks++; if (out_u !== 64'h0 || out_c !== 64'h0) begin n_errors++;
      $display("FAIL reset_rails u=%h c=%h want 0/0", out_u, out_c); end
    n_checks++; if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0 || a_busy !== 1'b0 || b_busy !== 1'b0) begin n_errors++;
      $display("FAIL reset_variants a_v=%b b_v=%b want 0", a_out_valid, b_out_valid); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1) begin n_errors++;
      $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_known_vector();
    int lat;
    out_ready = 1'b1;
    accept(64'h0123456789ABCDEF);
    wait_valid(lat);
    n_checks++; if (lat != LAT) begin n_errors++; $display("FAIL kv_latency got=%0d want=%0d", lat, LAT); end
    n_checks++; if (out_u !== 64'hC56B90AD3EF84712) begin n_errors++;
      $display("FAIL kv_out_u got=%h want=C56B90AD3EF84712", out_u); end
    n_checks++; if (out_c !== 64'h3A946F52C107B8ED) begin n_errors++;
      $display("FAIL kv_out_c got=%h want=3A946F52C107B8ED", out_c); end
    n_checks++; if (fault !== 1'b0) begin n_errors++; $display("FAIL kv_fault got=%b want=0", fault); end
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_errors++;
      $display("FAIL kv_release valid=%b ready=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_hold();
    int lat;
    out_ready = 1'b0;
    accept(64'h0);
    wait_valid(lat);
    n_checks++; if (lat != LAT) begin n_errors++; $display("FAIL hold_latency got=%0d want=%0d", lat, LAT); end
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_data  = rnd64();
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_errors++;
        $display("FAIL hold_handshake cyc=%0d valid=%b ready=%b want 1/0", i, out_valid, in_ready); end
      n_checks++; if (out_u !== 64'hCCCCCCCCCCCCCCCC || out_c !== 64'h3333333333333333) begin n_errors++;
        $display("FAIL hold_rails cyc=%0d u=%h c=%h want CCCC../3333..", i, out_u, out_c); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_errors++;
      $display("FAIL hold_release valid=%b ready=%b want 0/1", out_valid, in_ready); end
    n_checks++; if (out_u !== 64'hCCCCCCCCCCCCCCCC) begin n_errors++;
      $display("FAIL hold_rails_kept u=%h want CCCCCCCCCCCCCCCC", out_u); end
  endtask

  task automatic test_phases();
    logic [63:0]  x;
    logic [127:0] r;
    logic         exp_pre, exp_valid;
    x = rnd64();
    out_ready = 1'b1;
    accept(x);
    for (int t = 0; t <= LAT; t++) begin
      exp_valid = (t == LAT);
      exp_pre   = !exp_valid && ((t % (P + 1)) < P);
      r = ref_rails(x, t / (P + 1), L);
      n_checks++; if (pre_phase !== exp_pre || out_valid !== exp_valid) begin n_errors++;
        $display("FAIL phase_flags t=%0d pre=%b valid=%b want %b/%b", t, pre_phase, out_valid, exp_pre, exp_valid); end
      n_checks++; if (out_u !== r[127:64] || out_c !== r[63:0]) begin n_errors++;
        $display("FAIL phase_rails t=%0d u=%h c=%h want %h/%h", t, out_u, out_c, r[127:64], r[63:0]); end
      if (t < LAT) begin @(posedge clk); #1; end
    end
    n_checks++; if ((out_u ^ out_c) !== 64'hFFFFFFFFFFFFFFFF) begin n_errors++;
      $display("FAIL phase_complement xor=%h want all ones", out_u ^ out_c); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat;
    out_ready = 1'b1;
    accept(rnd64());
    repeat (2 * (P + 1)) @(posedge clk);
    #1;
    n_checks++; if (pre_phase !== 1'b1) begin n_errors++; $display("FAIL mid_in_pre got=%b want=1", pre_phase); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({out_valid, pre_phase, busy, fault} !== 4'b0 || out_u !== 64'h0 || out_c !== 64'h0) begin n_errors++;
      $display("FAIL mid_reset flags=%b u=%h c=%h want all 0", {out_valid, pre_phase, busy, fault}, out_u, out_c); end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_errors++;
      $display("FAIL mid_ready ready=%b busy=%b want 1/0", in_ready, busy); end
    accept(64'hFFFFFFFFFFFFFFFF);
    wait_valid(lat);
    n_checks++; if (lat != LAT) begin n_errors++; $display("FAIL mid_latency got=%0d want=%0d", lat, LAT); end
    n_checks++; if (out_u !== 64'h2222222222222222 || out_c !== 64'hDDDDDDDDDDDDDDDD) begin n_errors++;
      $display("FAIL mid_result u=%h c=%h want 2222../DDDD..", out_u, out_c); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int lat, d;
    logic [63:0]  x;
    logic [127:0] r;
    for (int k = 0; k < 6; k++) begin
      x = rnd64();
      d = $urandom_range(0, 3);
      r = ref_rails(x, 16, 1);
      out_ready = (d == 0);
      accept(x);
      wait_valid(lat);
      n_checks++; if (lat != LAT) begin n_errors++; $display("FAIL rnd_latency k=%0d got=%0d want=%0d", k, lat, LAT); end
      n_checks++; if (out_u !== r[127:64] || out_c !== r[63:0] || fault !== 1'b0) begin n_errors++;
        $display("FAIL rnd_result k=%0d x=%h u=%h c=%h f=%b want %h/%h/0", k, x, out_u, out_c, fault, r[127:64], r[63:0]); end
      repeat (d) begin
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b1 || out_u !== r[127:64]) begin n_errors++;
          $display("FAIL rnd_stall k=%0d valid=%b u=%h want 1/%h", k, out_valid, out_u, r[127:64]); end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [63:0]  x, nx;
    logic [127:0] r;
    out_ready = 1'b1;
    x = rnd64();
    in_data = x; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      nx = rnd64();
      in_data = nx;
      r = ref_rails(x, 16, 1);
      wait_valid(lat);
      n_checks++; if (lat != LAT || out_u !== r[127:64] || out_c !== r[63:0]) begin n_errors++;
        $display("FAIL b2b_result k=%0d lat=%0d u=%h c=%h want %0d/%h/%h", k, lat, out_u, out_c, LAT, r[127:64], r[63:0]); end
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_errors++;
        $display("FAIL b2b_no_overlap k=%0d valid=%b ready=%b want 0/1", k, out_valid, in_ready); end
      x = nx;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(lat);
    @(posedge clk); #1;
  endtask

`ifdef PRESENT_SBOX_FAULT_INJECT_EN
  task automatic test_fault_inject();
    int lat;
    out_ready = 1'b1;
    inj_mask = 16'h0001;
    accept(64'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    inj_mask = 16'h0000;
    wait_valid(lat);
    n_checks++; if (fault !== 1'b1) begin n_errors++; $display("FAIL inj_fault got=%b want=1", fault); end
    n_checks++; if (out_u !== 64'hCCCCCCCCCCCCCCCD || out_c !== 64'h3333333333333333) begin n_errors++;
      $display("FAIL inj_rails u=%h c=%h want CCCCCCCCCCCCCCCD/3333333333333333", out_u, out_c); end
    @(posedge clk); #1;
    accept(rnd64());
    n_checks++; if (fault !== 1'b0) begin n_errors++; $display("FAIL inj_clear got=%b want=0", fault); end
    wait_valid(lat);
    n_checks++; if (fault !== 1'b0) begin n_errors++; $display("FAIL inj_done_clean got=%b want=0", fault); end
    @(posedge clk); #1;
  endtask
`endif

  task automatic test_lanes1();
    int lat;
    logic [63:0]  x;
    logic [127:0] r;
    for (int k = 0; k < 2; k++) begin
      x = rnd64();
      r = ref_rails(x, 16, 1);
      a_in_data = x; a_in_valid = 1'b1;
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      lat = 0;
      while (a_out_valid !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
      n_checks++; if (lat != 48) begin n_errors++; $display("FAIL l1_latency k=%0d got=%0d want=48", k, lat); end
      n_checks++; if (a_out_u !== r[127:64] || a_out_c !== r[63:0] || a_fault !== 1'b0) begin n_errors++;
        $display("FAIL l1_result k=%0d u=%h c=%h want %h/%h", k, a_out_u, a_out_c, r[127:64], r[63:0]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lanes16();
    int lat;
    logic [63:0]  x;
    logic [127:0] r;
    for (int k = 0; k < 4; k++) begin
      x = rnd64();
      r = ref_rails(x, 16, 1);
      b_in_data = x; b_in_valid = 1'b1;
      @(posedge clk); #1;
      b_in_valid = 1'b0;
      n_checks++; if (b_pre_phase !== 1'b1 || b_out_u !== 64'h0) begin n_errors++;
        $display("FAIL l16_precharge k=%0d pre=%b u=%h want 1/0", k, b_pre_phase, b_out_u); end
      lat = 0;
      while (b_out_valid !== 1'b1 && lat < 50) begin @(posedge clk); #1; lat++; end
      n_checks++; if (lat != 3) begin n_errors++; $display("FAIL l16_latency k=%0d got=%0d want=3", k, lat); end
      n_checks++; if (b_out_u !== r[127:64] || b_out_c !== r[63:0] || b_fault !== 1'b0) begin n_errors++;
        $display("FAIL l16_result k=%0d u=%h c=%h want %h/%h", k, b_out_u, b_out_c, r[127:64], r[63:0]); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_known_vector();
    test_hold();
    test_phases();
    test_reset_mid();
    test_random();
    test_back_to_back();
`ifdef PRESENT_SBOX_FAULT_INJECT_EN
    test_fault_inject();
`endif
    test_lanes1();
    test_lanes16();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
